// File: rtl/uart_rx.sv
// uart_rx: 16x-oversampled UART receiver with a one-entry holding register.
// Optional feature macro UART_RX_RTS_EN: rts_n mirrors the holding-register full flag.
module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       rx,
    input  logic [1:0] data_bit_num,
    input  logic       stop_bit_num,
    input  logic       parity_en,
    input  logic       parity_type,
    input  logic       rd_en,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun_err,
    output logic       rts_n
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_e;

    state_e     state_q, state_d;
    logic       rx_meta_q, rxs_q;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic       stop_cnt_q, stop_cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [1:0] dbn_q, dbn_d;
    logic       sbn_q, sbn_d;
    logic       pen_q, pen_d;
    logic       ptype_q, ptype_d;
    logic       perr_q, perr_d;
    logic       ferr_q, ferr_d;

    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       parity_err_q, parity_err_d;
    logic       frame_err_q, frame_err_d;
    logic       overrun_q, overrun_d;

    logic       mid_bit;
    logic       last_data;
    logic       last_stop;
    logic       commit;

    // Expected parity bit: even parity is the plain XOR, odd parity its inverse.
    function automatic logic parity_expect(input logic [7:0] d, input logic even);
        return (^d) ^ ~even;
    endfunction

    assign mid_bit   = (tick_cnt_q == 4'hF);
    assign last_data = (bit_cnt_q == (3'd4 + {1'b0, dbn_q}));
    assign last_stop = (stop_cnt_q == sbn_q);
    assign commit    = tick && (state_q == STOP) && mid_bit && last_stop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rxs_q     <= rx_meta_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                IDLE:    if (!rxs_q) state_d = START;
                START:   if (tick_cnt_q == 4'd7) state_d = rxs_q ? IDLE : DATA;
                DATA:    if (mid_bit && last_data) state_d = pen_q ? PARITY : STOP;
                PARITY:  if (mid_bit) state_d = STOP;
                STOP:    if (mid_bit && last_stop) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Frame datapath: oversampling counter, bit assembly and per-frame error flags.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        shift_d    = shift_q;
        dbn_d      = dbn_q;
        sbn_d      = sbn_q;
        pen_d      = pen_q;
        ptype_d    = ptype_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        if (tick) begin
            case (state_q)
                IDLE: begin
                    tick_cnt_d = 4'd0;
                    if (!rxs_q) begin
                        bit_cnt_d  = 3'd0;
                        stop_cnt_d = 1'b0;
                        shift_d    = 8'd0;
                        perr_d     = 1'b0;
                        ferr_d     = 1'b0;
                        dbn_d      = data_bit_num;
                        sbn_d      = stop_bit_num;
                        pen_d      = parity_en;
                        ptype_d    = parity_type;
                    end
                end
                START: begin
                    tick_cnt_d = (tick_cnt_q == 4'd7) ? 4'd0 : tick_cnt_q + 4'd1;
                end
                DATA: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (mid_bit) begin
                        shift_d[bit_cnt_q] = rxs_q;
                        bit_cnt_d          = last_data ? 3'd0 : bit_cnt_q + 3'd1;
                    end
                end
                PARITY: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (mid_bit && (rxs_q != parity_expect(shift_q, ptype_q))) begin
                        perr_d = 1'b1;
                    end
                end
                STOP: begin
                    tick_cnt_d = tick_cnt_q + 4'd1;
                    if (mid_bit) begin
                        if (!rxs_q) ferr_d = 1'b1;
                        stop_cnt_d = 1'b1;
                    end
                end
                default: tick_cnt_d = 4'd0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt_q <= 4'd0;
            bit_cnt_q  <= 3'd0;
            stop_cnt_q <= 1'b0;
            shift_q    <= 8'd0;
            dbn_q      <= 2'd0;
            sbn_q      <= 1'b0;
            pen_q      <= 1'b0;
            ptype_q    <= 1'b0;
            perr_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            shift_q    <= shift_d;
            dbn_q      <= dbn_d;
            sbn_q      <= sbn_d;
            pen_q      <= pen_d;
            ptype_q    <= ptype_d;
            perr_q     <= perr_d;
            ferr_q     <= ferr_d;
        end
    end

    // Holding register: a same-cycle read frees the slot before the commit lands.
    always_comb begin
        rx_data_d    = rx_data_q;
        rx_valid_d   = rx_valid_q;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        overrun_d    = 1'b0;
        if (rd_en && rx_valid_q) begin
            rx_valid_d   = 1'b0;
            parity_err_d = 1'b0;
            frame_err_d  = 1'b0;
        end
        if (commit) begin
            if (rx_valid_d) begin
                overrun_d = 1'b1;
            end else begin
                rx_data_d    = shift_q;
                rx_valid_d   = 1'b1;
                parity_err_d = perr_q;
                frame_err_d  = ferr_q | ~rxs_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data_q    <= 8'd0;
            rx_valid_q   <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            rx_data_q    <= rx_data_d;
            rx_valid_q   <= rx_valid_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overrun_q    <= overrun_d;
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_q;

`ifdef UART_RX_RTS_EN
    logic rts_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rts_q <= 1'b0;
        end else begin
            rts_q <= rx_valid_d;
        end
    end

    assign rts_n = rts_q;
`else
    assign rts_n = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: frame-level reference model with randomized frames, reads and line errors.
`timescale 1ns/1ps
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rx = 1'b1;
    logic [1:0] data_bit_num = 2'b11;
    logic       stop_bit_num = 1'b0;
    logic       parity_en = 1'b0;
    logic       parity_type = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, parity_err, frame_err, overrun_err, rts_n;

    int n_cmp = 0;
    int n_err = 0;

`ifdef UART_RX_RTS_EN
    localparam logic RTS_FULL = 1'b1;
`else
    localparam logic RTS_FULL = 1'b0;
`endif

    uart_rx dut (
        .clk(clk), .rst(rst), .tick(tick), .rx(rx),
        .data_bit_num(data_bit_num), .stop_bit_num(stop_bit_num),
        .parity_en(parity_en), .parity_type(parity_type), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .parity_err(parity_err),
        .frame_err(frame_err), .overrun_err(overrun_err), .rts_n(rts_n)
    );

    always #5 clk = ~clk;

    int tdiv = 0;
    always @(posedge clk) begin
        #1;
        tdiv = (tdiv + 1) % 4;
        tick = (tdiv == 0);
    end

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Frame-level reference: each frame is reduced to (commit tick, data, perr, ferr).
    typedef struct {
        longint     target;
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t       pend[$];
    longint     tk = 0;
    logic [7:0] m_data = 8'd0;
    logic       m_valid = 1'b0, m_perr = 1'b0, m_ferr = 1'b0, m_ovr = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_data = 8'd0; m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0; m_ovr = 1'b0;
            pend.delete();
        end else begin
            m_ovr = 1'b0;
            if (rd_en && m_valid) begin
                m_valid = 1'b0; m_perr = 1'b0; m_ferr = 1'b0;
            end
            if (tick) begin
                tk++;
                if (pend.size() > 0 && pend[0].target == tk) begin
                    if (m_valid) m_ovr = 1'b1;
                    else begin
                        m_data = pend[0].data; m_perr = pend[0].perr;
                        m_ferr = pend[0].ferr; m_valid = 1'b1;
                    end
                    void'(pend.pop_front());
                end
            end
        end
    end

    logic cmp_en = 1'b0;
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("rx_valid", rx_valid, m_valid);
            chk("rx_data", rx_data, m_data);
            chk("parity_err", parity_err, m_perr);
            chk("frame_err", frame_err, m_ferr);
            chk("overrun_err", overrun_err, m_ovr);
            chk("rts_n", rts_n, RTS_FULL & m_valid);
        end
    end

    int ovr_cnt = 0;
    always @(negedge clk) if (overrun_err === 1'b1) ovr_cnt++;

    int rd_req = 0, rd_done = 0;
    bit rand_rd = 1'b0;
    always @(posedge clk) begin
        #1;
        if (rd_req != rd_done) begin
            rd_en = 1'b1;
            rd_done++;
        end else begin
            rd_en = rand_rd && ($urandom_range(0, 299) == 0);
        end
    end

    task automatic wait_tick();
        do @(posedge clk); while (tick !== 1'b1);
    endtask

    task automatic do_read();
        rd_req++;
        wait (rd_done == rd_req);
        @(posedge clk);
        #2;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic [1:0] dbn, input logic sb,
                              input logic pen, input logic ptype, input logic par,
                              input logic s0, input logic s1);
        logic       bits [12];
        int         n, len, ones;
        logic [7:0] dm;
        exp_t       e;
        n  = 5 + int'(dbn);
        dm = 8'd0;
        for (int i = 0; i < n; i++) dm[i] = d[i];
        bits[0] = 1'b0;
        for (int i = 0; i < n; i++) bits[1 + i] = d[i];
        len = 1 + n;
        if (pen) begin bits[len] = par; len++; end
        bits[len] = s0; len++;
        if (sb) begin bits[len] = s1; len++; end
        ones   = $countones(dm) + ((pen && par) ? 1 : 0);
        e.data = dm;
        e.perr = pen && (((ones % 2) == 1) == ptype);
        e.ferr = !s0 || (sb && !s1);
        data_bit_num = dbn; stop_bit_num = sb; parity_en = pen; parity_type = ptype;
        wait_tick(); #1;
        e.target = tk + 9 + 16 * (len - 1);
        pend.push_back(e);
        for (int j = 0; j < len; j++) begin
            rx = bits[j];
            repeat (16) wait_tick();
            #1;
        end
        rx = 1'b1;
        repeat (3) wait_tick();
        #1;
    endtask

    initial begin
        int ovr0;
        logic [7:0] d;
        logic [1:0] dbn;
        logic sb, pen, ptype, par, s0, s1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_valid", rx_valid, 1'b0);
        chk("reset_data", rx_data, 8'h00);
        chk("reset_rts", rts_n, 1'b0);
        cmp_en = 1'b1;
        rst = 1'b0;
        repeat (4) wait_tick(); #1;

        send_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("a5_valid", rx_valid, 1'b1);
        chk("a5_data", rx_data, 8'hA5);
        chk("a5_errs", {parity_err, frame_err}, 2'b00);
        do_read();
        chk("a5_read", rx_valid, 1'b0);

        send_frame(8'h55, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("7e1_bad_data", rx_data, 8'h55);
        chk("7e1_bad_perr", parity_err, 1'b1);
        do_read();
        send_frame(8'h55, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("7e1_ok_perr", parity_err, 1'b0);
        chk("7e1_ok_valid", rx_valid, 1'b1);
        do_read();

        wait_tick(); #1;
        rx = 1'b0;
        repeat (4) wait_tick(); #1;
        rx = 1'b1;
        repeat (14) wait_tick(); #1;
        chk("glitch_valid", rx_valid, 1'b0);

        send_frame(8'h1F, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("5n2_data", rx_data, 8'h1F);
        chk("5n2_ferr", frame_err, 1'b1);
        do_read();
        chk("5n2_read_ferr", frame_err, 1'b0);

        ovr0 = ovr_cnt;
        send_frame(8'h11, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_rts_first", rts_n, RTS_FULL);
        send_frame(8'h22, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("ovr_data", rx_data, 8'h11);
        chk("ovr_pulses", 8'(ovr_cnt - ovr0), 8'd1);
        chk("ovr_rts", rts_n, RTS_FULL);
        do_read();
        chk("ovr_rts_read", rts_n, 1'b0);

        wait_tick(); #1;
        rx = 1'b0;
        repeat (16) wait_tick(); #1;
        rx = 1'b1;
        repeat (24) wait_tick(); #1;
        rx = 1'b0;
        repeat (8) wait_tick(); #1;
        rst = 1'b1;
        rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_valid", rx_valid, 1'b0);
        rst = 1'b0;
        repeat (4) wait_tick(); #1;
        send_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("midrst_data", rx_data, 8'h3C);
        chk("midrst_errs", {parity_err, frame_err}, 2'b00);
        do_read();

        rand_rd = 1'b1;
        for (int f = 0; f < 40; f++) begin
            d     = 8'($urandom);
            dbn   = 2'($urandom);
            sb    = 1'($urandom);
            pen   = 1'($urandom);
            ptype = 1'($urandom);
            par   = 1'b0;
            for (int i = 0; i < 5 + int'(dbn); i++) par ^= d[i];
            if (!ptype) par = ~par;
            if ($urandom_range(0, 5) == 0) par = ~par;
            s0 = ($urandom_range(0, 7) != 0);
            s1 = ($urandom_range(0, 7) != 0);
            send_frame(d, dbn, sb, pen, ptype, par, s0, s1);
            repeat ($urandom_range(0, 20)) wait_tick();
            #1;
        end
        rand_rd = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
